// File: rtl/adc_responder_pkg.sv
// Shared types and defaults for the parallel-ADC responder model.
package adc_pkg;

  localparam int unsigned ADC_DATA_W      = 8;
  localparam int unsigned ADC_CONV_CYCLES = 100;
  localparam int unsigned ADC_MIN_WR      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_e;

  // Timer must hold CONV_CYCLES-1, sized generously as clog2(CONV_CYCLES+1).
  function automatic int unsigned adc_timer_w(input int unsigned conv_cycles);
    return $clog2(conv_cycles + 1);
  endfunction

endpackage

// File: rtl/adc_responder_if.sv
// Converter-side bus: chip select, start/read strobes, data bus and EOC.
interface adc_responder_if #(
  parameter int unsigned DATA_W = adc_pkg::ADC_DATA_W
) ();

  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              int_n;

  // Communicator (host) side.
  modport master (
    output cs_n, wr_n, rd_n,
    input  data_out, data_oe, int_n
  );

  // Converter (responder) side.
  modport slave (
    input  cs_n, wr_n, rd_n,
    output data_out, data_oe, int_n
  );

endinterface

// File: rtl/adc_responder_conv_timer.sv
// Loadable down-counter that times the conversion; zero flag marks expiry.
module adc_conv_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats load, decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/adc_responder.sv
// Responder side of the 8-bit parallel ADC handshake: stands in for the
// converter, track-and-holds sample_in on a valid WR release and raises
// EOC (int_n low) a fixed number of clocks later.
module adc_responder
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W        = ADC_DATA_W,
  parameter int unsigned CONV_CYCLES   = ADC_CONV_CYCLES,
  parameter int unsigned MIN_WR_CYCLES = ADC_MIN_WR
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_responder_if.slave      bus,
  input  logic [DATA_W-1:0]   sample_in,
  output logic                wr_err,
  output logic [7:0]          conv_cnt
);

  localparam int unsigned TMR_W = adc_timer_w(CONV_CYCLES);
  localparam int unsigned LOW_W = $clog2(MIN_WR_CYCLES + 1);

  localparam logic [LOW_W-1:0] MIN_WR_L  = LOW_W'(MIN_WR_CYCLES);
  localparam logic [LOW_W-1:0] LOW_ONE   = LOW_W'(1);
  localparam logic [TMR_W-1:0] TMR_START = TMR_W'(CONV_CYCLES - 1);

  adc_state_e        state_q,    state_d;
  logic [LOW_W-1:0]  low_cnt_q,  low_cnt_d;
  logic [DATA_W-1:0] hold_q,     hold_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              int_n_q,    int_n_d;
  logic              wr_err_q,   wr_err_d;
  logic [7:0]        conv_cnt_q, conv_cnt_d;

  logic strobe;
  logic rd;
  logic tmr_load;
  logic tmr_clear;
  logic tmr_en;
  logic tmr_zero;

  assign strobe = ~bus.cs_n & ~bus.wr_n;
  assign rd     = ~bus.cs_n & ~bus.rd_n;

  adc_conv_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .en       (tmr_en),
    .load_val (TMR_START),
    .zero     (tmr_zero)
  );

  // Handshake FSM next-state and output decisions.
  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    int_n_d    = int_n_q;
    wr_err_d   = 1'b0;
    conv_cnt_d = conv_cnt_q;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d   = ARMED;
          int_n_d   = 1'b1;
          low_cnt_d = LOW_ONE;
        end
      end

      ARMED: begin
        if (strobe) begin
          if (low_cnt_q < MIN_WR_L) begin
            low_cnt_d = low_cnt_q + 1'b1;
          end
        end else if (low_cnt_q >= MIN_WR_L) begin
          hold_d   = sample_in;
          tmr_load = 1'b1;
          state_d  = CONVERT;
        end else begin
          wr_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      CONVERT: begin
        // A new strobe restarts even if the timer expires on the same edge.
        if (strobe) begin
          state_d   = ARMED;
          low_cnt_d = LOW_ONE;
          tmr_clear = 1'b1;
        end else if (tmr_zero) begin
          data_out_d = hold_q;
          int_n_d    = 1'b0;
          conv_cnt_d = conv_cnt_q + 8'd1;
          state_d    = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      DONE: begin
        if (strobe) begin
          state_d   = ARMED;
          int_n_d   = 1'b1;
          low_cnt_d = LOW_ONE;
        end else if (rd) begin
          state_d = IDLE;
          int_n_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        int_n_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      low_cnt_q  <= '0;
      hold_q     <= '0;
      data_out_q <= '0;
      int_n_q    <= 1'b1;
      wr_err_q   <= 1'b0;
      conv_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      int_n_q    <= int_n_d;
      wr_err_q   <= wr_err_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = rd;
  assign bus.int_n    = int_n_q;
  assign wr_err       = wr_err_q;
  assign conv_cnt     = conv_cnt_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed self-checking bench for adc_responder (CONV_CYCLES=10, MIN_WR=2).
module tb_adc_responder;

  localparam int unsigned CONV = 10;
  localparam int unsigned MINW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       wr_err;
  logic [7:0] conv_cnt;

  int n_checks = 0;
  int n_errors = 0;

  adc_responder_if #(.DATA_W(8)) bus ();

  adc_responder #(
    .DATA_W        (8),
    .CONV_CYCLES   (CONV),
    .MIN_WR_CYCLES (MINW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sample_in (sample_in),
    .wr_err    (wr_err),
    .conv_cnt  (conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until int_n is seen low; lat = edges after the current one, 0 on timeout.
  task automatic wait_int(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.int_n == 1'b0) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int saw_low;
    int saw_err;

    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.rd_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check("rst_int_n",    32'(bus.int_n),    32'h1);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_wr_err",   32'(wr_err),       32'h0);
    check("rst_conv_cnt", 32'(conv_cnt),     32'h0);

    // Valid 3-cycle strobe, A5 at release.
    bus.cs_n  = 1'b0;
    bus.wr_n  = 1'b0;
    sample_in = 8'hA5;
    tick();
    check("t1_int_n_first_low", 32'(bus.int_n), 32'h1);
    tick();
    tick();
    bus.wr_n = 1'b1;
    tick();
    sample_in = 8'h00;
    wait_int(lat);
    check("t1_latency", 32'(lat),          32'(CONV));
    check("t1_data",    32'(bus.data_out), 32'hA5);
    check("t1_cnt",     32'(conv_cnt),     32'h1);

    // Read in DONE.
    bus.rd_n = 1'b0;
    #1;
    check("t4_oe_on", 32'(bus.data_oe), 32'h1);
    tick();
    check("t4_int_n_after_rd", 32'(bus.int_n),    32'h1);
    check("t4_data_held",      32'(bus.data_out), 32'hA5);
    bus.rd_n = 1'b1;
    #1;
    check("t4_oe_off", 32'(bus.data_oe), 32'h0);

    // Short 1-cycle strobe from IDLE.
    bus.wr_n = 1'b0;
    tick();
    bus.wr_n = 1'b1;
    tick();
    check("t2_wr_err_pulse", 32'(wr_err), 32'h1);
    tick();
    check("t2_wr_err_clear", 32'(wr_err), 32'h0);
    saw_low = 0;
    saw_err = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.int_n == 1'b0) saw_low = 1;
      if (wr_err == 1'b1) saw_err = 1;
    end
    check("t2_no_completion", 32'(saw_low),  32'h0);
    check("t2_single_err",    32'(saw_err),  32'h0);
    check("t2_cnt",           32'(conv_cnt), 32'h1);

    // Restart 4 cycles into CONVERT.
    bus.wr_n  = 1'b0;
    sample_in = 8'h11;
    tick();
    tick();
    bus.wr_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    bus.wr_n  = 1'b0;
    sample_in = 8'h3C;
    tick();
    tick();
    bus.wr_n = 1'b1;
    tick();
    sample_in = 8'h00;
    wait_int(lat);
    check("t3_latency", 32'(lat),          32'(CONV));
    check("t3_data",    32'(bus.data_out), 32'h3C);
    check("t3_cnt",     32'(conv_cnt),     32'h2);

    // Reset during the 5th CONVERT cycle.
    bus.wr_n  = 1'b0;
    sample_in = 8'h77;
    tick();
    check("t5_int_n_rise_from_done", 32'(bus.int_n), 32'h1);
    tick();
    bus.wr_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_int_n", 32'(bus.int_n),    32'h1);
    check("t5_data",  32'(bus.data_out), 32'h0);
    check("t5_cnt",   32'(conv_cnt),     32'h0);
    tick();
    rst_n = 1'b1;
    saw_low = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.int_n == 1'b0) saw_low = 1;
    end
    check("t5_no_late_eoc", 32'(saw_low), 32'h0);

    // 256 back-to-back conversions; strobe issued as soon as int_n is low.
    for (int j = 0; j < 256; j++) begin
      bus.wr_n  = 1'b0;
      sample_in = 8'(j);
      tick();
      check("t6_int_n_rise", 32'(bus.int_n), 32'h1);
      tick();
      bus.wr_n = 1'b1;
      tick();
      sample_in = ~8'(j);
      wait_int(lat);
      check("t6_latency", 32'(lat),          32'(CONV));
      check("t6_data",    32'(bus.data_out), 32'(j));
    end
    check("t6_cnt_wrap", 32'(conv_cnt), 32'h0);

    // Read and strobe together in DONE: strobe wins.
    bus.wr_n  = 1'b0;
    bus.rd_n  = 1'b0;
    sample_in = 8'h5A;
    tick();
    check("t7_int_n_rise", 32'(bus.int_n), 32'h1);
    bus.rd_n = 1'b1;
    tick();
    bus.wr_n = 1'b1;
    tick();
    check("t7_no_wr_err", 32'(wr_err), 32'h0);
    wait_int(lat);
    check("t7_latency", 32'(lat),          32'(CONV));
    check("t7_data",    32'(bus.data_out), 32'h5A);
    check("t7_cnt",     32'(conv_cnt),     32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
# adc_responder

Synthesizable responder side of the 8-bit parallel ADC handshake (WR start strobe, active-low INT end-of-conversion, 8-bit data bus, optional RD). It stands in for the external converter: it accepts a start strobe from the communicator and track-and-holds a digital `sample_in` from a plant or stimulus model. After a fixed conversion time it presents the result and pulls `int_n` low. It is used for closed-loop bench and FPGA-in-the-loop runs of the PWM/PI control path.

## Interface
- `DATA_W`, 8: width of `sample_in` and `data_out`.
- `CONV_CYCLES`, 100: clocks from the WR rising edge to `int_n` falling. Legal range is 1 or more.
- `MIN_WR_CYCLES`, 2: minimum consecutive low samples of `wr_n` for a valid start. Legal range is 1 or more.
- `clk`  in  1: single clock. All inputs are synchronous to it.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cs_n`  in  1: chip select, active-low. When high, `wr_n` and `rd_n` are ignored.
- `wr_n`  in  1: start-of-conversion strobe, active-low.
- `rd_n`  in  1: read strobe, active-low. Optional; tie high if unused.
- `sample_in`  in  DATA_W: analogue value to be converted.
- `data_out`  out  DATA_W: last completed result. Always driven; the value is held between conversions.
- `data_oe`  out  1: `~cs_n & ~rd_n` (combinational). Pad-enable hint only.
- `int_n`  out  1: end-of-conversion, active-low.
- `wr_err`  out  1: one-cycle pulse when a start strobe is rejected because it is shorter than `MIN_WR_CYCLES`.
- `conv_cnt`  out  8: count of completed conversions. Wraps 255→0.

## Operation
- Reset values: `int_n`=1, `data_out`=0, `wr_err`=0, `conv_cnt`=0, state IDLE, timer 0. Reset mid-conversion discards the conversion; no completion follows.
- "Strobe low" means `cs_n`=0 and `wr_n`=0 at a clock edge.
- States:
  - **IDLE**: on strobe low → ARMED, `int_n`←1, `low_cnt`←1.
  - **ARMED**: while strobe low, `low_cnt` increments and saturates at `MIN_WR_CYCLES`.
    - On the first sample with the strobe not low, if `low_cnt` ≥ `MIN_WR_CYCLES`: capture `sample_in` into the hold register, load timer with `CONV_CYCLES`-1, go to CONVERT.
    - Otherwise pulse `wr_err` and go to IDLE, with `int_n` left at 1.
  - **CONVERT**: timer decrements each cycle.
    - When the timer is 0: `data_out`←hold register, `int_n`←0, `conv_cnt`++, go to DONE.
    - A strobe low in CONVERT aborts the conversion: no completion, no `conv_cnt` increment, go to ARMED with `low_cnt`←1 (restart).
  - **DONE**: `int_n` stays 0.
    - Read (`cs_n`=0, `rd_n`=0) → `int_n`←1, go to IDLE.
    - Strobe low → `int_n`←1, go to ARMED with `low_cnt`←1.
    - If read and strobe occur in the same cycle, the strobe wins (go to ARMED). Either way `int_n` rises.
- Reads in IDLE, ARMED or CONVERT do not change state. `data_out` keeps the previous result until the next completion.
- `sample_in` wider than the result is not allowed. `data_out` equals the captured value bit-exact; there is no scaling.

## Timing
- Edge numbering: every output is registered except `data_oe`. A change decided at edge k is visible after edge k.
- Strobe first sampled low at edge n → `int_n`=1 after edge n.
- WR released (first non-low sample) at edge m, valid pulse:
  - `sample_in` is sampled at edge m.
  - `int_n` falls and `data_out` updates after edge m+`CONV_CYCLES`, in the same cycle.
  - `conv_cnt` increments at that same edge.
- Short pulse released at edge m → `wr_err`=1 for the single cycle after edge m.
- Read sampled at edge r in DONE → `int_n`=1 after edge r. `data_out` is unchanged.
- Minimum start-to-start period is `MIN_WR_CYCLES`+`CONV_CYCLES`+1 clocks. Back-to-back strobes issued immediately on `int_n` low are accepted with no lost cycle.

## Structure
- Package `adc_pkg`:
  - state enum {IDLE, ARMED, CONVERT, DONE} (2 bits);
  - default constants `ADC_DATA_W`=8, `ADC_CONV_CYCLES`=100, `ADC_MIN_WR`=2;
  - timer width derived as $clog2(CONV_CYCLES+1).
- Sub-module `adc_conv_timer`: a loadable down-counter with a `load`/`clear` input and a `zero` flag. The FSM, hold register and counters stay in `adc_responder`.

## Test plan
- Reset release, then `wr_n` low 3 cycles with `sample_in`=8'hA5 at release, CONV_CYCLES=10 → `int_n` high from the first low sample; `int_n`=0 and `data_out`=8'hA5 exactly 10 cycles after release; `conv_cnt`=1.
- 1-cycle `wr_n` pulse with MIN_WR_CYCLES=2 → `wr_err` pulses once; no completion; `int_n` stays 1; `conv_cnt` unchanged.
- Second strobe 4 cycles into CONVERT with `sample_in`=8'h3C at its release → only one completion, at release+10; `data_out`=8'h3C; `conv_cnt` increments by 1.
- In DONE, assert `rd_n`=0 and `cs_n`=0 for one cycle → `int_n`=1 the next cycle; `data_oe`=1 only while asserted; `data_out` held.
- `rst_n` low at cycle 5 of CONVERT → `int_n`=1, `data_out`=0, `conv_cnt`=0 immediately; no later `int_n` fall.
- 256 valid conversions back-to-back → `conv_cnt` wraps to 0; each `int_n` fall is exactly CONV_CYCLES after its release.
